// File: rtl/alerta_sonoro_pkg.sv
// ---------------------------------------------------------------------------
// alerta_sonoro_pkg
// Shared definitions for the headlight-warning chime driver.
//   estado_t : FSM state encoding (3 bits) used by alerta_sonoro
//   max3     : helper that sizes the shared state timer from the largest
//              of the three interval parameters
// ---------------------------------------------------------------------------
package alerta_sonoro_pkg;

   // Chime FSM states: idle, beeping, gap between beeps, gap between
   // bursts, and muted by the driver.
   typedef enum logic [2:0] {
      OCIOSO    = 3'd0,
      BIPE      = 3'd1,
      INTERVALO = 3'd2,
      PAUSA     = 3'd3,
      MUDO      = 3'd4
   } estado_t;

   // Largest of three values, used to size the single timer that is
   // reused by the BIPE, INTERVALO and PAUSA states.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/alerta_sonoro_filtro.sv
// ---------------------------------------------------------------------------
// filtro_entrada
// Two-flop synchronizer followed by a debounce filter for one raw level.
// The filtered output only follows the synchronized input once the two
// have disagreed for DEB consecutive cycles.
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  synchronous active-high reset, clears all flops
//   entrada in  raw asynchronous level
//   saida   out filtered level
// ---------------------------------------------------------------------------
module filtro_entrada #(
   parameter int unsigned DEB = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic entrada,
   output logic saida
);

   localparam int CW = $clog2(DEB) + 1;
   localparam logic [CW-1:0] FIM_DEB = CW'(DEB - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          filt_q,  filt_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   // Next-state for the synchronizer chain and the debounce counter.
   // The counter only advances while the synchronized level disagrees
   // with the filtered one; any cycle of agreement starts it over, so a
   // short glitch never reaches the output. When the DEB-th disagreeing
   // cycle is seen, the filtered level flips and the counter restarts.
   always_comb begin
      sync1_d = entrada;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == FIM_DEB) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Register everything; reset returns the chain and filter to zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign saida = filt_q;

endmodule

// File: rtl/alerta_sonoro.sv
// ---------------------------------------------------------------------------
// alerta_sonoro
// Piezo chime driver for the headlight warning. The filtered warning starts
// bursts of N_BIPES tone beeps separated by short gaps, with a long pause
// between bursts. A rising edge on the silence button mutes the chime until
// the warning clears.
// Ports:
//   clock     in  system clock, rising edge
//   reset     in  synchronous active-high reset, clears all state
//   alerta    in  raw warning level (1 = warning)
//   silenciar in  silence button level, rising edge acts
//   buzzer    out tone output to the piezo driver
//   ativo     out 1 while a burst pattern runs (BIPE/INTERVALO/PAUSA)
//   mudo      out 1 while muted
// ---------------------------------------------------------------------------
module alerta_sonoro
   import alerta_sonoro_pkg::*;
#(
   parameter int unsigned DEB         = 50000,
   parameter int unsigned DIV_TOM     = 12500,
   parameter int unsigned T_LIGADO    = 5000000,
   parameter int unsigned T_DESLIGADO = 2500000,
   parameter int unsigned N_BIPES     = 3,
   parameter int unsigned T_PAUSA     = 25000000
) (
   input  logic clock,
   input  logic reset,
   input  logic alerta,
   input  logic silenciar,
   output logic buzzer,
   output logic ativo,
   output logic mudo
);

   localparam int unsigned T_MAX = max3(T_LIGADO, T_DESLIGADO, T_PAUSA);
   localparam int TW = $clog2(T_MAX) + 1;
   localparam int DW = $clog2(DIV_TOM) + 1;
   localparam int BW = $clog2(N_BIPES) + 1;

   localparam logic [TW-1:0] FIM_LIGADO    = TW'(T_LIGADO - 1);
   localparam logic [TW-1:0] FIM_DESLIGADO = TW'(T_DESLIGADO - 1);
   localparam logic [TW-1:0] FIM_PAUSA     = TW'(T_PAUSA - 1);
   localparam logic [DW-1:0] FIM_TOM       = DW'(DIV_TOM - 1);
   localparam logic [BW-1:0] ULTIMO_BIPE   = BW'(N_BIPES - 1);

   logic          alerta_f;
   logic          subida_silenciar;

   estado_t       estado_q,        estado_d;
   logic [TW-1:0] timer_q,         timer_d;
   logic [DW-1:0] tom_q,           tom_d;
   logic [BW-1:0] bipes_q,         bipes_d;
   logic          buzzer_q,        buzzer_d;
   logic          ativo_q,         ativo_d;
   logic          mudo_q,          mudo_d;
   logic          silenciar_ant_q, silenciar_ant_d;

   filtro_entrada #(
      .DEB(DEB)
   ) u_filtro_alerta (
      .clock  (clock),
      .reset  (reset),
      .entrada(alerta),
      .saida  (alerta_f)
   );

   assign subida_silenciar = silenciar & ~silenciar_ant_q;

   // FSM next state, counters and outputs. The warning dropping wins over
   // everything and sends us idle at once (no beep is allowed to finish).
   // Next comes a fresh press of the silence button, which only matters
   // while a burst is running. Only then do the timers drive the pattern.
   // Every state entry clears the timer and the tone divider, and the
   // buzzer value is computed for the state being entered so that the
   // registered outputs line up with the registered state.
   always_comb begin
      estado_d        = estado_q;
      timer_d         = timer_q;
      tom_d           = tom_q;
      bipes_d         = bipes_q;
      buzzer_d        = buzzer_q;
      silenciar_ant_d = silenciar;

      if (!alerta_f) begin
         estado_d = OCIOSO;
         timer_d  = '0;
         tom_d    = '0;
         bipes_d  = '0;
         buzzer_d = 1'b0;
      end else if (subida_silenciar &&
                   (estado_q == BIPE || estado_q == INTERVALO ||
                    estado_q == PAUSA)) begin
         estado_d = MUDO;
         timer_d  = '0;
         tom_d    = '0;
         bipes_d  = '0;
         buzzer_d = 1'b0;
      end else begin
         case (estado_q)
            OCIOSO: begin
               estado_d = BIPE;
               timer_d  = '0;
               tom_d    = '0;
               bipes_d  = '0;
               buzzer_d = 1'b1;
            end
            BIPE: begin
               if (timer_q == FIM_LIGADO) begin
                  timer_d  = '0;
                  tom_d    = '0;
                  buzzer_d = 1'b0;
                  if (bipes_q == ULTIMO_BIPE) begin
                     estado_d = PAUSA;
                     bipes_d  = '0;
                  end else begin
                     estado_d = INTERVALO;
                     bipes_d  = bipes_q + BW'(1);
                  end
               end else begin
                  timer_d = timer_q + TW'(1);
                  if (tom_q == FIM_TOM) begin
                     tom_d    = '0;
                     buzzer_d = ~buzzer_q;
                  end else begin
                     tom_d = tom_q + DW'(1);
                  end
               end
            end
            INTERVALO: begin
               buzzer_d = 1'b0;
               if (timer_q == FIM_DESLIGADO) begin
                  estado_d = BIPE;
                  timer_d  = '0;
                  tom_d    = '0;
                  buzzer_d = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            PAUSA: begin
               buzzer_d = 1'b0;
               if (timer_q == FIM_PAUSA) begin
                  estado_d = BIPE;
                  timer_d  = '0;
                  tom_d    = '0;
                  buzzer_d = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            MUDO: begin
               buzzer_d = 1'b0;
            end
            default: begin
               estado_d = OCIOSO;
               timer_d  = '0;
               tom_d    = '0;
               bipes_d  = '0;
               buzzer_d = 1'b0;
            end
         endcase
      end

      ativo_d = (estado_d == BIPE) || (estado_d == INTERVALO) ||
                (estado_d == PAUSA);
      mudo_d  = (estado_d == MUDO);
   end

   // Single register stage for the FSM, its counters and all outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q        <= OCIOSO;
         timer_q         <= '0;
         tom_q           <= '0;
         bipes_q         <= '0;
         buzzer_q        <= 1'b0;
         ativo_q         <= 1'b0;
         mudo_q          <= 1'b0;
         silenciar_ant_q <= 1'b0;
      end else begin
         estado_q        <= estado_d;
         timer_q         <= timer_d;
         tom_q           <= tom_d;
         bipes_q         <= bipes_d;
         buzzer_q        <= buzzer_d;
         ativo_q         <= ativo_d;
         mudo_q          <= mudo_d;
         silenciar_ant_q <= silenciar_ant_d;
      end
   end

   assign buzzer = buzzer_q;
   assign ativo  = ativo_q;
   assign mudo   = mudo_q;

endmodule
